// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read-side consumer feeding a valid/ready stream through a small output queue.
// Optional read-word counter rd_count built when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream #(
   parameter int DATASIZE   = 8,
   parameter int OBUF_DEPTH = 2,
   parameter int CNTW       = 16,
   localparam int LW = $clog2(OBUF_DEPTH + 1),
   localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                fifo_empty,
   output logic                ren,
   input  logic [DATASIZE-1:0] mem_dout,
   output logic [DATASIZE-1:0] m_data,
   output logic                m_valid,
   input  logic                m_ready,
`ifdef FIFO_RD_STATS_EN
   output logic [LW-1:0]       level,
   output logic [CNTW-1:0]     rd_count
`else
   output logic [LW-1:0]       level
`endif
);
   logic [DATASIZE-1:0] mem [OBUF_DEPTH];
   logic [AW-1:0] rd_idx, wr_idx;
   logic          rd_pend, pop;
   logic [LW:0]   credit;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] i);
      return (i == AW'(OBUF_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   assign m_valid = level != '0;
   assign pop     = m_valid & m_ready;
   // Count the in-flight word too so the queue can never overflow
   assign credit  = {1'b0, level} + (LW+1)'(rd_pend) - (LW+1)'(pop);
   assign ren     = ~rst_i & ~fifo_empty & (credit < (LW+1)'(OBUF_DEPTH));
   assign m_data  = m_valid ? mem[rd_idx] : '0;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         rd_pend <= 1'b0;
         level   <= '0;
         rd_idx  <= '0;
         wr_idx  <= '0;
      end else begin
         rd_pend <= ren;
         level   <= level + LW'(rd_pend) - LW'(pop);
         if (rd_pend) wr_idx <= nxt(wr_idx);
         if (pop) rd_idx <= nxt(rd_idx);
      end

   always_ff @(posedge clk_i)
      if (rd_pend) mem[wr_idx] <= mem_dout;

`ifdef FIFO_RD_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) rd_count <= '0;
      else if (pop) rd_count <= rd_count + 1'b1;
`else
`endif
endmodule
